uart_frame_scheduler: RTL

UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

---
 rtl/uart_frame_scheduler_if.sv | 23 ++
 rtl/uart_frame_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_scheduler_if.sv
// Bus between the frame scheduler and its surroundings: channel samples in, UART byte handshake out.
// master = scheduler side, slave = sample source / UART transmitter side.
interface uart_frame_scheduler_if #(
    parameter int NUM_CH = 4
);
    logic [8*NUM_CH-1:0] ch_data;
    logic [NUM_CH-1:0]   ch_en;
    logic                tx_done;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                frame_done;
    logic                overrun;

    modport master (
        input  ch_data, ch_en, tx_done,
        output tx_start, tx_data, frame_done, overrun
    );

    modport slave (
        output ch_data, ch_en, tx_done,
        input  tx_start, tx_data, frame_done, overrun
    );
endinterface

// File: rtl/uart_frame_scheduler.sv
// Periodic UART frame builder: header 0xA5, channel mask, then one byte per enabled channel.
// Optional trailing XOR checksum byte when FRAME_CHECKSUM_EN is defined.
module uart_frame_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_frame_scheduler_if.master  bus
);
    localparam int         CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int         IDX_W    = $clog2(NUM_CH + 1);
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_MASK = 3'd2,
        S_DATA = 3'd3,
`ifdef FRAME_CHECKSUM_EN
        S_CSUM = 3'd4,
`endif
        S_WAIT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    state_t              sent_q, sent_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ch_idx_q, ch_idx_d;
    logic [NUM_CH-1:0]   en_snap_q, en_snap_d;
    logic [8*NUM_CH-1:0] data_snap_q, data_snap_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                overrun_q, overrun_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                tick;
    logic                frame_done_c;
    logic [NUM_CH-1:0]   rem;
    logic                sel_en;
    logic [7:0]          sel_byte;
    logic                issue;
    logic [7:0]          issue_byte;
    logic                frame_end;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Enabled channels not yet visited; empty means the last sample has gone out.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rem
            assign rem[gi] = en_snap_q[gi] && (IDX_W'(gi) >= ch_idx_q);
        end
    endgenerate

    always_comb begin
        sel_en   = 1'b0;
        sel_byte = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (IDX_W'(k) == ch_idx_q) begin
                sel_en   = en_snap_q[k];
                sel_byte = data_snap_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sent_d       = sent_q;
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        ch_idx_d     = ch_idx_q;
        en_snap_d    = en_snap_q;
        data_snap_d  = data_snap_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        overrun_d    = overrun_q | (tick && (state_q != S_IDLE));
        frame_done_c = 1'b0;
        issue        = 1'b0;
        issue_byte   = 8'h00;
        frame_end    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    en_snap_d   = bus.ch_en;
                    data_snap_d = bus.ch_data;
                    ch_idx_d    = '0;
`ifdef FRAME_CHECKSUM_EN
                    csum_d      = 8'h00;
`endif
                    if (|bus.ch_en) state_d = S_HDR;
                end
            end
            S_HDR: begin
                issue      = 1'b1;
                issue_byte = HDR_BYTE;
                sent_d     = S_HDR;
                state_d    = S_WAIT;
            end
            S_MASK: begin
                issue      = 1'b1;
                issue_byte = 8'(en_snap_q);
                sent_d     = S_MASK;
                state_d    = S_WAIT;
            end
            S_DATA: begin
                // A disabled channel costs exactly one cycle here and sends nothing.
                ch_idx_d = ch_idx_q + 1'b1;
                if (sel_en) begin
                    issue      = 1'b1;
                    issue_byte = sel_byte;
                    sent_d     = S_DATA;
                    state_d    = S_WAIT;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CSUM: begin
                issue      = 1'b1;
                issue_byte = csum_q;
                sent_d     = S_CSUM;
                state_d    = S_WAIT;
            end
`endif
            S_WAIT: begin
                if (bus.tx_done) begin
                    case (sent_q)
                        S_HDR:  state_d = S_MASK;
                        S_MASK: state_d = S_DATA;
                        S_DATA: begin
                            if (|rem) begin
                                state_d = S_DATA;
                            end else begin
`ifdef FRAME_CHECKSUM_EN
                                state_d = S_CSUM;
`else
                                frame_end = 1'b1;
`endif
                            end
                        end
                        default: frame_end = 1'b1;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_end) begin
            frame_done_c = 1'b1;
            state_d      = S_IDLE;
        end

        if (issue) begin
            tx_start_d = 1'b1;
            tx_data_d  = issue_byte;
`ifdef FRAME_CHECKSUM_EN
            csum_d     = csum_q ^ issue_byte;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sent_q      <= S_IDLE;
            cnt_q       <= '0;
            ch_idx_q    <= '0;
            en_snap_q   <= '0;
            data_snap_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            overrun_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            sent_q      <= sent_d;
            cnt_q       <= cnt_d;
            ch_idx_q    <= ch_idx_d;
            en_snap_q   <= en_snap_d;
            data_snap_q <= data_snap_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            overrun_q   <= overrun_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_done = frame_done_c;
endmodule
